// File: rtl/mul_div_unit_pkg.sv
// ============================================================================
// mul_div_unit_pkg : op encodings, FSM states and helpers shared by the
//                    decoder and the multiply/divide unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  localparam logic [4:0] LAST_STEP = 5'd31;

  function automatic logic op_is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input mdu_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_rs1_signed(input mdu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_rs2_signed(input mdu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_special.sv
// ============================================================================
// mdu_special : detects divide-by-zero and signed overflow and supplies the
//               architecturally fixed result for those cases.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_special
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mdu_op_e         i_op,
  input  logic [XLEN-1:0] i_1,
  input  logic [XLEN-1:0] i_2,
  output logic            o_special,
  output logic [XLEN-1:0] o_result
);

  logic            w_div_zero;
  logic            w_overflow;
  logic [XLEN-1:0] w_int_min;

  always_comb begin
    w_int_min            = '0;
    w_int_min[XLEN-1]    = 1'b1;
    w_div_zero           = op_is_div(i_op) && (i_2 == '0);
    w_overflow           = ((i_op == OP_DIV) || (i_op == OP_REM)) &&
                           (i_1 == w_int_min) && (i_2 == '1);
    o_special            = w_div_zero | w_overflow;
    o_result             = '0;
    if (w_div_zero) begin
      o_result = op_is_rem(i_op) ? i_1 : '1;
    end else if (w_overflow) begin
      o_result = op_is_rem(i_op) ? '0 : w_int_min;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// mul_div_unit : iterative radix-2 multiply / restoring divide on operand
//                magnitudes, with sign fix-up and special-case bypass.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_ctrl,
  input  logic [XLEN-1:0] i_1,
  input  logic [XLEN-1:0] i_2,
  input  logic            i_kill,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_1
);

  mdu_state_e      state_q, state_d;
  mdu_op_e         op_q, op_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic            special_q, special_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] o1_q, o1_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  mdu_op_e           w_op_in;
  logic              w_accept;
  logic              w_s1, w_s2;
  logic [XLEN-1:0]   w_abs1, w_abs2;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN-1:0]   w_addend;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_shift;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_sub;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;

  assign w_op_in  = mdu_op_e'(i_ctrl);
  assign w_accept = i_start && !i_kill && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign w_s1     = op_rs1_signed(w_op_in) & i_1[XLEN-1];
  assign w_s2     = op_rs2_signed(w_op_in) & i_2[XLEN-1];
  assign w_abs1   = w_s1 ? -i_1 : i_1;
  assign w_abs2   = w_s2 ? -i_2 : i_2;

  mdu_special #(
    .XLEN (XLEN)
  ) u_special (
    .i_op      (w_op_in),
    .i_1       (i_1),
    .i_2       (i_2),
    .o_special (w_special),
    .o_result  (w_special_res)
  );

  // Multiply: {hi,lo} holds the partial product with the multiplier in lo.
  // Divide:   hi is the partial remainder, lo shifts dividend out / quotient in.
  assign w_addend    = lo_q[0] ? opnd_q : '0;
  assign w_mul_sum   = {1'b0, hi_q} + {1'b0, w_addend};
  assign w_div_shift = {hi_q, lo_q[XLEN-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, opnd_q});
  assign w_div_sub   = w_div_shift[XLEN-1:0] - opnd_q;
  assign w_prod      = {hi_q, lo_q};
  assign w_prod_fix  = neg_q ? -w_prod : w_prod;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    special_d = special_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    res_d     = res_q;
    o1_d      = o1_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_CALC: begin
        if (special_q) begin
          o1_d    = res_q;
          state_d = ST_DONE;
        end else begin
          if (op_is_div(op_q)) begin
            hi_d = w_div_ge ? w_div_sub : w_div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], w_div_ge};
          end else begin
            hi_d = w_mul_sum[XLEN:1];
            lo_d = {w_mul_sum[0], lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST_STEP) begin
            state_d = ST_FIX;
          end
        end
      end
      // Two phases: negate/select into res_q, then publish, keeping the
      // 64-bit negate off the o_1 load path.
      ST_FIX: begin
        if (cnt_q == 5'd0) begin
          if (op_is_rem(op_q)) begin
            res_d = neg_q ? -hi_q : hi_q;
          end else if (op_is_div(op_q)) begin
            res_d = neg_q ? -lo_q : lo_q;
          end else if (op_q == OP_MUL) begin
            res_d = w_prod_fix[XLEN-1:0];
          end else begin
            res_d = w_prod_fix[2*XLEN-1:XLEN];
          end
          cnt_d = 5'd1;
        end else begin
          o1_d    = res_q;
          cnt_d   = 5'd0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_accept) begin
      op_d      = w_op_in;
      cnt_d     = 5'd0;
      neg_d     = (w_op_in == OP_REM) ? w_s1 : (w_s1 ^ w_s2);
      special_d = w_special;
      res_d     = w_special_res;
      hi_d      = '0;
      lo_d      = op_is_div(w_op_in) ? w_abs1 : w_abs2;
      opnd_d    = op_is_div(w_op_in) ? w_abs2 : w_abs1;
      state_d   = ST_CALC;
    end

    if (i_kill) begin
      state_d = ST_IDLE;
      o1_d    = o1_q;
    end

    busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= 5'd0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      res_q     <= '0;
      o1_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      res_q     <= res_d;
      o1_q      <= o1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_1    = o1_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// tb_mul_div_unit : directed vector table plus kill / reset / back-to-back
//                   sequences for mul_div_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

  localparam logic [2:0] C_MUL    = 3'b000;
  localparam logic [2:0] C_MULH   = 3'b001;
  localparam logic [2:0] C_MULHSU = 3'b010;
  localparam logic [2:0] C_MULHU  = 3'b011;
  localparam logic [2:0] C_DIV    = 3'b100;
  localparam logic [2:0] C_DIVU   = 3'b101;
  localparam logic [2:0] C_REM    = 3'b110;
  localparam logic [2:0] C_REMU   = 3'b111;
  localparam int         NVEC     = 22;

  typedef struct {
    string       name;
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill  = 1'b0;
  logic [2:0]  ctrl  = 3'b000;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy;
  logic        done;
  logic [31:0] res;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  mul_div_unit #(
    .XLEN (32)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_ctrl  (ctrl),
    .i_1     (a),
    .i_2     (b),
    .i_kill  (kill),
    .o_busy  (busy),
    .o_done  (done),
    .o_1     (res)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called just after an edge; returns just after the accepting edge.
  task automatic start_op(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    ctrl  = c;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Edges counted from the accepting edge; 0 means o_done never rose.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int cnt;

    vecs[0]  = '{"mul_7x-3",       C_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    vecs[1]  = '{"mul_-5x-6",      C_MUL,    32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0000001E, 34};
    vecs[2]  = '{"mul_2^16sq",     C_MUL,    32'h00010000, 32'h00010000, 32'h00000000, 34};
    vecs[3]  = '{"mulh_min_sq",    C_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34};
    vecs[4]  = '{"mulh_-1x-1",     C_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34};
    vecs[5]  = '{"mulhu_max_sq",   C_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vecs[6]  = '{"mulhu_2^16sq",   C_MULHU,  32'h00010000, 32'h00010000, 32'h00000001, 34};
    vecs[7]  = '{"mulhsu_-1x2",    C_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34};
    vecs[8]  = '{"mulhsu_2xmax",   C_MULHSU, 32'd2,        32'hFFFFFFFF, 32'h00000001, 34};
    vecs[9]  = '{"div_-7/2",       C_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    vecs[10] = '{"rem_-7/2",       C_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    vecs[11] = '{"divu_100/7",     C_DIVU,   32'd100,      32'd7,        32'd14,       34};
    vecs[12] = '{"remu_100/7",     C_REMU,   32'd100,      32'd7,        32'd2,        34};
    vecs[13] = '{"div_7/-2",       C_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    vecs[14] = '{"rem_7/-2",       C_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 34};
    vecs[15] = '{"remu_max/16",    C_REMU,   32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 34};
    vecs[16] = '{"divu_5/0",       C_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[17] = '{"rem_5/0",        C_REM,    32'd5,        32'd0,        32'd5,        1};
    vecs[18] = '{"div_ovf",        C_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[19] = '{"rem_ovf",        C_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[20] = '{"divu_min/max",   C_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34};
    vecs[21] = '{"div_0/0",        C_DIV,    32'd0,        32'd0,        32'hFFFFFFFF, 1};

    // Reset state
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_o1", res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < NVEC; v++) begin
      start_op(vecs[v].ctrl, vecs[v].a, vecs[v].b);
      chk({vecs[v].name, "_busy"}, {31'd0, busy}, 32'd1);
      wait_done(n);
      chk({vecs[v].name, "_lat"}, n, vecs[v].lat);
      chk({vecs[v].name, "_res"}, res, vecs[v].exp);
      @(posedge clk);
      #1;
      chk({vecs[v].name, "_pulse"}, {31'd0, done}, 32'd0);
      chk({vecs[v].name, "_hold"}, res, vecs[v].exp);
    end

    // i_start during CALC is ignored
    start_op(C_MUL, 32'd7, 32'hFFFFFFFD);
    repeat (4) @(posedge clk);
    #1;
    ctrl  = C_DIVU;
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    chk("ign_start_lat", (n == 0) ? 0 : n + 5, 34);
    chk("ign_start_res", res, 32'hFFFFFFEB);

    // Kill in CALC cycle 10
    start_op(C_DIVU, 32'd100, 32'd7);
    wait_done(n);
    chk("pre_kill_res", res, 32'd14);
    start_op(C_MUL, 32'd7, 32'hFFFFFFFD);
    repeat (9) @(posedge clk);
    #1;
    chk("kill_busy_before", {31'd0, busy}, 32'd1);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("kill_busy_after", {31'd0, busy}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    chk("kill_no_done", cnt, 0);
    chk("kill_o1_kept", res, 32'd14);

    // Kill and start together in IDLE: no accept
    ctrl  = C_MUL;
    a     = 32'd3;
    b     = 32'd3;
    start = 1'b1;
    kill  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    kill  = 1'b0;
    chk("killstart_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("killstart_done", {31'd0, done}, 32'd0);

    // Reset mid-CALC
    start_op(C_DIVU, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_o1", res, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    chk("midrst_no_done", cnt, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ctrl  = C_REMU;
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    chk("postrst_lat", n, 34);
    chk("postrst_res", res, 32'd2);

    // Back-to-back: second start issued while in DONE
    start_op(C_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(n);
    chk("b2b_first_res", res, 32'hFFFFFFFD);
    start_op(C_MULHU, 32'h00010000, 32'h00010000);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    chk("b2b_second_lat", n, 34);
    chk("b2b_second_res", res, 32'h00000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_start  input  1  request pulse; operands and op sampled when accepted.
REQ-005 SHALL have port i_ctrl  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port i_1  input  32  rs1 operand (multiplicand/dividend).
REQ-007 SHALL have port i_2  input  32  rs2 operand (multiplier/divisor).
REQ-008 SHALL have port i_kill  input  1  pipeline flush; aborts the operation in flight.
REQ-009 SHALL have port o_busy  output  1  high while an operation is in flight.
REQ-010 SHALL have port o_done  output  1  one-cycle pulse, o_1 valid.
REQ-011 SHALL have port o_1  output  32  result, held from o_done until the next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE; reset state IDLE.
REQ-013 SHALL accept i_start only in IDLE or DONE with i_kill low; i_start in CALC/FIX is ignored.
REQ-014 SHALL on accept latch |i_1|, |i_2| (signed per op), result-sign flags and op, clear the 5-bit step counter, and enter CALC.
REQ-015 SHALL in CALC perform one radix-2 step per cycle (shift-add for MUL*, restoring shift-subtract for DIV*/REM*) over 32 cycles, then enter FIX.
REQ-016 SHALL in FIX negate the 64-bit product or the quotient/remainder per latched sign flags, select low/high word or quotient/remainder, load o_1, and enter DONE.
REQ-017 SHALL assert o_done only in DONE; DONE lasts one cycle, then IDLE (or CALC on back-to-back accept).
REQ-018 SHALL give latency: o_done high in the cycle after the 34th rising edge following the accepting edge, for all iterative ops.
REQ-019 SHALL on divide by zero (i_2 = 0) skip CALC/FIX: DIV/DIVU -> 0xFFFFFFFF, REM/REMU -> i_1; o_done after the 1st edge following acceptance (accept -> DONE).
REQ-020 SHALL on signed overflow (DIV/REM, i_1 = 0x80000000, i_2 = 0xFFFFFFFF) skip CALC/FIX: DIV -> 0x80000000, REM -> 0; same latency as REQ-019.
REQ-021 SHALL for MULHSU treat i_1 as signed and i_2 as unsigned; MULH both signed; MULHU both unsigned.
REQ-022 SHALL on i_kill high at any edge go to IDLE, suppress o_done, and leave o_1 unchanged; i_kill with i_start in the same cycle: kill wins, no accept.
REQ-023 SHALL keep o_busy = 1 exactly in CALC and FIX.

Reset
REQ-024 SHALL on i_rst_n low immediately force IDLE, o_busy = 0, o_done = 0, o_1 = 0, counter = 0, all datapath registers = 0.
REQ-025 SHALL treat reset mid-operation as an abort: no o_done after release; the first edge with i_rst_n high may accept i_start.

Structure
REQ-026 SHALL place the i_ctrl op encodings and the FSM state enum in the shared processor package, shared with the decoder.
REQ-027 SHALL place the special-case detection (zero divisor, overflow) and the constant results in a sub-module mdu_special; the iterative datapath stays in mul_div_unit.

Verification
REQ-028 SHALL cover MUL 7 x -3 -> o_1 = 0xFFFFFFEB, o_done exactly 34 edges after accept.
REQ-029 SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 x 2 -> 0xFFFFFFFF.
REQ-030 SHALL cover DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF, DIVU 100/7 -> 14, REMU 100/7 -> 2.
REQ-031 SHALL cover DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, each with o_done 1 edge after accept.
REQ-032 SHALL cover i_kill asserted in CALC cycle 10 -> IDLE next edge, no o_done, o_1 retains prior value; i_start during CALC -> ignored.
REQ-033 SHALL cover i_rst_n pulsed low mid-CALC -> outputs 0 immediately, no o_done; back-to-back starts in DONE -> second result correct.
